// File: rtl/skid_reg_if.sv
// Handshake bundle between a producer, the skid register and a consumer.
// The slave modport is the skid register's view; master is the environment driving it.
interface skid_reg_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_in;
    logic                  ready_out;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_out;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport slave (
        input  valid_in,
        input  data_in,
        input  ready_in,
        output ready_out,
        output valid_out,
        output data_out
    );

    modport master (
        output valid_in,
        output data_in,
        output ready_in,
        input  ready_out,
        input  valid_out,
        input  data_out
    );
endinterface

// File: rtl/skid_reg.sv
// Two-entry handshaked pipeline register with registered ready_out and a skid entry.
// Optional synchronous flush port is enabled by defining SKID_REG_FLUSH_EN.
module skid_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic       clock_in,
    input  logic       reset_in,
`ifdef SKID_REG_FLUSH_EN
    input  logic       flush_in,
`endif
    skid_reg_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  valid_out_q, valid_out_d;
    logic                  ready_out_q, ready_out_d;
    logic                  accept;
    logic                  deliver;

    assign accept  = bus.valid_in & ready_out_q;
    assign deliver = valid_out_q & bus.ready_in;

    // Outputs are derived from the next state so they leave the block straight from flops.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = bus.data_in;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && deliver) begin
                    main_d = bus.data_in;
                end else if (accept) begin
                    skid_d  = bus.data_in;
                    state_d = FULL;
                end else if (deliver) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (deliver) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

`ifdef SKID_REG_FLUSH_EN
        if (flush_in) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
`endif

        valid_out_d = (state_d != EMPTY);
        ready_out_d = (state_d != FULL);
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            valid_out_q <= 1'b0;
            ready_out_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            valid_out_q <= valid_out_d;
            ready_out_q <= ready_out_d;
        end
    end

    assign bus.valid_out = valid_out_q;
    assign bus.ready_out = ready_out_q;
    assign bus.data_out  = main_q;

endmodule

// File: tb/tb_skid_reg.sv
// Directed and randomised checks for skid_reg against hand-computed values and a FIFO model.
// Covers the SKID_REG_FLUSH_EN flush behaviour when that macro is defined.
module tb_skid_reg;

    localparam int DW = 32;

    logic clock_in;
    logic reset_in;
    logic flush_in;

    int compared;
    int mismatched;

    skid_reg_if #(.DATA_WIDTH(DW)) bus ();

    skid_reg #(.DATA_WIDTH(DW)) dut (
        .clock_in (clock_in),
        .reset_in (reset_in),
`ifdef SKID_REG_FLUSH_EN
        .flush_in (flush_in),
`endif
        .bus      (bus.slave)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r);
        bus.valid_in = v;
        bus.data_in  = d;
        bus.ready_in = r;
    endtask

    task automatic checkValue(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic er,
                               input logic [DW-1:0] ed, input bit check_data);
        checkValue({tag, ".valid_out"}, {31'd0, bus.valid_out}, {31'd0, ev});
        checkValue({tag, ".ready_out"}, {31'd0, bus.ready_out}, {31'd0, er});
        if (check_data)
            checkValue({tag, ".data_out"}, bus.data_out, ed);
    endtask

    initial begin
        logic [DW-1:0] model_q[$];
        logic [DW-1:0] word;
        logic          v, r, acc, del, holding;
        int            sent, recv, cycles;

        compared   = 0;
        mismatched = 0;
        flush_in   = 1'b0;
        reset_in   = 1'b1;
        applyStimulus(1'b1, 32'h1234_5678, 1'b1);

        // Reset state, held against live inputs
        tick();
        checkOutput("reset_hold", 1'b0, 1'b1, 32'h0, 1'b1);
        tick();
        reset_in = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("reset_release", 1'b0, 1'b1, 32'h0, 1'b1);

        $display("[TB] single word");
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1);
        tick();
        checkOutput("single_load", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("single_drain", 1'b0, 1'b1, 32'h0, 1'b0);

        $display("[TB] streaming 1..8");
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, DW'(i), 1'b1);
            tick();
            checkOutput($sformatf("stream_%0d", i), 1'b1, 1'b1, DW'(i), 1'b1);
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("stream_drain", 1'b0, 1'b1, 32'h0, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'd1, 1'b0);
        tick();
        checkOutput("bp_one", 1'b1, 1'b1, 32'd1, 1'b1);
        applyStimulus(1'b1, 32'd2, 1'b0);
        tick();
        checkOutput("bp_full", 1'b1, 1'b0, 32'd1, 1'b1);
        applyStimulus(1'b1, 32'd3, 1'b0);
        tick();
        checkOutput("bp_stall", 1'b1, 1'b0, 32'd1, 1'b1);
        applyStimulus(1'b1, 32'd3, 1'b1);
        tick();
        checkOutput("bp_out2", 1'b1, 1'b1, 32'd2, 1'b1);
        tick();
        checkOutput("bp_out3", 1'b1, 1'b1, 32'd3, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("bp_drain", 1'b0, 1'b1, 32'h0, 1'b0);

        $display("[TB] random traffic, 1000 words");
        sent    = 0;
        recv    = 0;
        cycles  = 0;
        holding = 1'b0;
        v       = 1'b0;
        word    = '0;
        while (recv < 1000 && cycles < 20000) begin
            checkValue("rnd.valid_out", {31'd0, bus.valid_out}, {31'd0, (model_q.size() != 0)});
            checkValue("rnd.ready_out", {31'd0, bus.ready_out}, {31'd0, (model_q.size() < 2)});
            if (model_q.size() != 0)
                checkValue("rnd.data_out", bus.data_out, model_q[0]);
            if (!holding) begin
                v    = (sent < 1000) && ($urandom_range(0, 1) == 1);
                word = $urandom;
            end
            r = ($urandom_range(0, 1) == 1);
            applyStimulus(v, word, r);
            acc = v & bus.ready_out;
            del = bus.valid_out & r;
            if (del && model_q.size() != 0) begin
                void'(model_q.pop_front());
                recv++;
            end
            if (acc) begin
                model_q.push_back(word);
                sent++;
            end
            holding = v & ~acc;
            tick();
            cycles++;
        end
        checkValue("rnd.words_delivered", DW'(recv), DW'(1000));
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("rnd_idle", 1'b0, 1'b1, 32'h0, 1'b0);

        $display("[TB] asynchronous reset in FULL");
        applyStimulus(1'b1, 32'hA, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hB, 1'b0);
        tick();
        checkOutput("ar_full", 1'b1, 1'b0, 32'hA, 1'b1);
        #2;
        reset_in = 1'b1;
        #1;
        checkOutput("ar_immediate", 1'b0, 1'b1, 32'h0, 1'b1);
        #1;
        reset_in = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("ar_after1", 1'b0, 1'b1, 32'h0, 1'b1);
        tick();
        checkOutput("ar_after2", 1'b0, 1'b1, 32'h0, 1'b1);

`ifdef SKID_REG_FLUSH_EN
        $display("[TB] flush in FULL");
        applyStimulus(1'b1, 32'h1, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h2, 1'b0);
        tick();
        checkOutput("fl_full", 1'b1, 1'b0, 32'h1, 1'b1);
        applyStimulus(1'b1, 32'hC, 1'b0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        checkOutput("fl_after", 1'b0, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("fl_quiet1", 1'b0, 1'b1, 32'h0, 1'b0);
        tick();
        checkOutput("fl_quiet2", 1'b0, 1'b1, 32'h0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
